// File: rtl/decimator_mc_if.sv
// Frame handshake bundle for decimator_mc.
// slave = decimator side, master = producer/consumer side.
interface decimator_mc_if #(
  parameter int W  = 16,
  parameter int CH = 4
);
  logic [W*CH-1:0] i_data;
  logic            i_ready;
  logic [W*CH-1:0] o_data;
  logic            o_ready;
  logic            i_accept;

  modport slave (
    input  i_data,
    input  i_ready,
    input  i_accept,
    output o_data,
    output o_ready
  );

  modport master (
    output i_data,
    output i_ready,
    output i_accept,
    input  o_data,
    input  o_ready
  );
endinterface

// File: rtl/decimator_mc.sv
// Multi-channel keep-last-of-M decimator with held output and overflow flag.
// Optional DECIM_DROP_CNT_EN adds a saturating dropped-frame counter.
module decimator_mc #(
  parameter int W     = 16,
  parameter int CH    = 4,
  parameter int MAX_M = 256,
  parameter int RW    = $clog2(MAX_M + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [RW-1:0] i_ratio,
  input  logic          i_clr,
  output logic          o_overflow,
`ifdef DECIM_DROP_CNT_EN
  output logic [15:0]   o_drop_cnt,
`endif
  decimator_mc_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W*CH-1:0] data_q, data_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   m_cur_q, m_cur_d;
  logic            ovf_q, ovf_d;
  logic            cap;
  logic            drop;

  // Zero means "no decimation"; anything above MAX_M clamps.
  function automatic logic [RW-1:0] sat(input logic [RW-1:0] x);
    if (x == '0)
      return RW'(1);
    else if (x > RW'(MAX_M))
      return RW'(MAX_M);
    else
      return x;
  endfunction

  always_comb begin
    cap     = bus.i_ready && (cnt_q == m_cur_q - RW'(1));
    cnt_d   = cnt_q;
    m_cur_d = m_cur_q;
    if (bus.i_ready) begin
      if (cap) begin
        cnt_d   = '0;
        m_cur_d = sat(i_ratio);
      end else begin
        cnt_d = cnt_q + RW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drop    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (cap) begin
          data_d  = bus.i_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.i_accept) begin
          if (cap)
            data_d = bus.i_data;
          else
            state_d = EMPTY;
        end else if (cap) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A drop in the clearing cycle still leaves the flag set.
    ovf_d = drop | (ovf_q & ~i_clr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
      m_cur_q <= sat(i_ratio);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      m_cur_q <= m_cur_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_ready = (state_q == FULL);
  assign o_overflow  = ovf_q;

`ifdef DECIM_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_clr)
      drop_cnt_d = {15'd0, drop};
    else if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      drop_cnt_q <= '0;
    else
      drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_decimator_mc.sv
// Directed self-checking bench for decimator_mc.
// Frame n carries a distinct, partly negative, value per channel.
module tb_decimator_mc;

  localparam int W     = 16;
  localparam int CH    = 4;
  localparam int MAX_M = 256;
  localparam int RW    = $clog2(MAX_M + 1);

  logic          clk;
  logic          rst_n;
  logic [RW-1:0] ratio;
  logic          clr;
  logic          ovf;
`ifdef DECIM_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int passed;
  int total;

  decimator_mc_if #(.W(W), .CH(CH)) bus ();

  decimator_mc #(.W(W), .CH(CH), .MAX_M(MAX_M)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ratio    (ratio),
    .i_clr      (clr),
    .o_overflow (ovf),
`ifdef DECIM_DROP_CNT_EN
    .o_drop_cnt (drop_cnt),
`endif
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W*CH-1:0] mk(input int n);
    logic [15:0] b;
    b = 16'(n);
    return {b + 16'hC000, b + 16'h8000, b + 16'h1000, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n);
    bus.i_data  = mk(n);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  task automatic do_reset(input logic [RW-1:0] r);
    rst_n = 1'b0;
    ratio = r;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst_n        = 1'b0;
    ratio        = RW'(5);
    clr          = 1'b0;
    bus.i_data   = '0;
    bus.i_ready  = 1'b0;
    bus.i_accept = 1'b0;

    // Reset state
    do_reset(RW'(5));
    chk("rst_ready", 64'(bus.o_ready), 64'(0));
    chk("rst_data", bus.o_data, 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));

    // M=5, continuous input, always accepting
    bus.i_accept = 1'b1;
    for (int n = 0; n < 15; n++) begin
      frame(n);
      chk("m5_ready", 64'(bus.o_ready), 64'(n % 5 == 4));
      if (n % 5 == 4) chk("m5_data", bus.o_data, mk(n));
    end
    chk("m5_ovf", 64'(ovf), 64'(0));

    // Ratio 0 -> M=1, then 300 clamps to 256
    do_reset(RW'(0));
    for (int n = 0; n < 3; n++) begin
      frame(n);
      chk("m1_ready", 64'(bus.o_ready), 64'(1));
      chk("m1_data", bus.o_data, mk(n));
    end
    ratio = RW'(300);
    frame(3);
    chk("m1_last", bus.o_data, mk(3));
    for (int n = 0; n < 256; n++) begin
      frame(100 + n);
      chk("m256_ready", 64'(bus.o_ready), 64'(n == 255));
    end
    chk("m256_data", bus.o_data, mk(355));

    // Ratio change mid-group does not truncate it
    do_reset(RW'(4));
    for (int n = 0; n < 8; n++) begin
      if (n == 2) ratio = RW'(2);
      frame(n);
      chk("chg_ready", 64'(bus.o_ready), 64'(n == 3 || n == 5 || n == 7));
      if (n == 3 || n == 5 || n == 7) chk("chg_data", bus.o_data, mk(n));
    end

    // Backpressure: M=2, no accept for 6 frames
    do_reset(RW'(2));
    bus.i_accept = 1'b0;
    for (int n = 0; n < 6; n++) frame(n);
    chk("bp_ready", 64'(bus.o_ready), 64'(1));
    chk("bp_data", bus.o_data, mk(1));
    chk("bp_ovf", 64'(ovf), 64'(1));
`ifdef DECIM_DROP_CNT_EN
    chk("bp_cnt", 64'(drop_cnt), 64'(2));
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", 64'(ovf), 64'(0));
`ifdef DECIM_DROP_CNT_EN
    chk("clr_cnt", 64'(drop_cnt), 64'(0));
`endif
    chk("clr_ready", 64'(bus.o_ready), 64'(1));
    bus.i_accept = 1'b1;
    tick();
    bus.i_accept = 1'b0;
    chk("acc_ready", 64'(bus.o_ready), 64'(0));
    chk("acc_hold", bus.o_data, mk(1));

    // Drop in the clearing cycle: set wins
    frame(6);
    frame(7);
    chk("sw_full", 64'(bus.o_ready), 64'(1));
    frame(8);
    clr = 1'b1;
    frame(9);
    clr = 1'b0;
    chk("sw_ovf", 64'(ovf), 64'(1));
    chk("sw_data", bus.o_data, mk(7));
`ifdef DECIM_DROP_CNT_EN
    chk("sw_cnt", 64'(drop_cnt), 64'(1));
`endif

    // FULL with accept in capture cycle: no bubble, no drop
    do_reset(RW'(2));
    frame(0);
    frame(1);
    frame(2);
    chk("pt_full", 64'(bus.o_ready), 64'(1));
    chk("pt_hold", bus.o_data, mk(1));
    bus.i_accept = 1'b1;
    frame(3);
    bus.i_accept = 1'b0;
    chk("pt_ready", 64'(bus.o_ready), 64'(1));
    chk("pt_data", bus.o_data, mk(3));
    chk("pt_ovf", 64'(ovf), 64'(0));

    // Reset mid-group while FULL
    do_reset(RW'(4));
    for (int n = 0; n < 7; n++) frame(n);
    chk("mr_full", 64'(bus.o_ready), 64'(1));
    bus.i_data  = mk(50);
    bus.i_ready = 1'b1;
    do_reset(RW'(4));
    bus.i_ready = 1'b0;
    chk("mr_ready", 64'(bus.o_ready), 64'(0));
    chk("mr_data", bus.o_data, 64'(0));
    chk("mr_ovf", 64'(ovf), 64'(0));
    for (int n = 0; n < 4; n++) begin
      frame(20 + n);
      chk("mr_seq", 64'(bus.o_ready), 64'(n == 3));
    end
    chk("mr_out", bus.o_data, mk(23));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
